// File: rtl/fetch_stage_pkg.sv
// fetch_stage_pkg: shared FSM encoding, entry layout and constants for the fetch stage
package fetch_stage_pkg;
  typedef enum logic [1:0] {
    IF_ISSUE = 2'd0,
    IF_WAIT  = 2'd1,
    IF_DRAIN = 2'd2
  } if_state_t;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } if_entry_t;
  localparam logic [31:0] NOP_INST = 32'h0;
  localparam logic [31:0] PC_INC   = 32'd4;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: 2-entry instruction buffer with flush; 1-bit pointers plus a 2-bit count
module fetch_fifo
  import fetch_stage_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic       pop,
  input  logic       flush,
  input  if_entry_t  din,
  output if_entry_t  head,
  output logic [1:0] count
);
  if_entry_t mem [2];
  logic wp, rp, do_push, do_pop;
  assign do_pop  = pop && count != 2'd0 && !flush;
  assign do_push = push && (count != 2'd2 || do_pop) && !flush;
  assign head    = mem[rp];
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wp    <= 1'b0;
      rp    <= 1'b0;
      count <= 2'd0;
    end else if (flush) begin
      wp    <= 1'b0;
      rp    <= 1'b0;
      count <= 2'd0;
    end else begin
      wp    <= wp ^ do_push;
      rp    <= rp ^ do_pop;
      count <= count + {1'b0, do_push} - {1'b0, do_pop};
    end
  always_ff @(posedge clk)
    if (do_push) mem[wp] <= din;
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: owns the PC, fetches one word at a time from imem and buffers results for decode
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_IF_stall,
  input  logic        i_IF_redirect,
  input  logic [31:0] i_IF_redirectPC,
  output logic        o_IF_imemReq,
  output logic [31:0] o_IF_imemAddr,
  input  logic        i_IF_imemGnt,
  input  logic        i_IF_imemRValid,
  input  logic [31:0] i_IF_imemRData,
  output logic        o_IF_valid,
  output logic [31:0] o_IF_PC,
  output logic [31:0] o_IF_inst
);
  if_state_t   state;
  logic [31:0] pc;
  logic [1:0]  count;
  if_entry_t   head;
  logic        accept, push;
  // Outstanding is zero only in ISSUE, so the credit check reduces to FIFO room.
  assign o_IF_imemReq  = !rst && state == IF_ISSUE && int'(count) < FIFO_DEPTH;
  assign o_IF_imemAddr = rst ? 32'h0 : pc;
  assign accept        = o_IF_imemReq && i_IF_imemGnt;
  // pc already points past the outstanding word, which is exactly the PC decode expects.
  assign push          = state == IF_WAIT && i_IF_imemRValid && !i_IF_redirect;
  assign o_IF_valid    = count != 2'd0;
  assign o_IF_PC       = o_IF_valid ? head.pc : 32'h0;
  assign o_IF_inst     = o_IF_valid ? head.inst : NOP_INST;
  fetch_fifo u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (!i_IF_stall),
    .flush (i_IF_redirect),
    .din   ('{pc: pc, inst: i_IF_imemRData}),
    .head  (head),
    .count (count)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IF_ISSUE;
      pc    <= RESET_PC;
    end else begin
      pc <= i_IF_redirect ? (i_IF_redirectPC & ~32'h3) : accept ? pc + PC_INC : pc;
      case (state)
        IF_ISSUE: state <= accept ? (i_IF_redirect ? IF_DRAIN : IF_WAIT) : IF_ISSUE;
        IF_WAIT:  state <= i_IF_imemRValid ? IF_ISSUE : i_IF_redirect ? IF_DRAIN : IF_WAIT;
        default:  state <= i_IF_imemRValid ? IF_ISSUE : IF_DRAIN;
      endcase
    end
endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch (IF) stage of the 5-stage MIPS pipeline, directly upstream of the decode stage.
- Owns the PC and issues word fetches to instruction memory over a req/grant/rvalid handshake, with variable latency.
- Buffers returned instructions in a 2-entry FIFO so a decode stall never drops a response.
- Applies branch/jump redirects from later stages, discarding stale in-flight data.

Parameters:
- RESET_PC, 32'h0000_0000, address of the first fetch after reset.
- FIFO_DEPTH, 2, instruction buffer entries; fixed at 2, and the pointer logic relies on it.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- i_IF_stall  in  1  decode pause; the head entry is held while it is high.
- i_IF_redirect  in  1  one-cycle pulse; a taken branch/jump was resolved.
- i_IF_redirectPC  in  32  new fetch address; bits [1:0] are ignored and forced to 0.
- o_IF_imemReq  out  1  fetch request.
- o_IF_imemAddr  out  32  word-aligned fetch address.
- i_IF_imemGnt  in  1  request accepted this cycle.
- i_IF_imemRValid  in  1  read data valid.
- i_IF_imemRData  in  32  instruction word.
- o_IF_valid  out  1  head of FIFO holds a valid instruction.
- o_IF_PC  out  32  fetch address + 4 of the head instruction, driven to decode's PC input.
- o_IF_inst  out  32  head instruction word; 32'h0 (nop) when o_IF_valid=0.

Behaviour:
- Reset (async, rst=1):
  - PC=RESET_PC, FIFO empty, outstanding=0, state=ISSUE.
  - o_IF_valid=0, o_IF_PC=0, o_IF_inst=0, o_IF_imemReq=0, o_IF_imemAddr=0.
  - First request is asserted in the first cycle after rst falls.
- Handshake and credits:
  - At most one request outstanding.
  - Request accepted on the edge where o_IF_imemReq=1 and i_IF_imemGnt=1.
  - Response arrives ≥1 cycle after acceptance.
  - o_IF_imemReq is asserted only when FIFO occupancy + outstanding < 2; this credit rule guarantees no overflow.
  - Req/addr are held stable until granted.
- FSM states:
  - ISSUE: req=1, addr=PC. On grant: PC<=PC+4, outstanding=1, next WAIT.
  - WAIT: on rvalid, push {addr+4, rdata} into the FIFO, outstanding=0, next ISSUE.
  - DRAIN: a redirect arrived while a request was outstanding. On rvalid, the data is discarded (no push) and the state returns to ISSUE with PC already = redirect target.
- Redirect (highest priority):
  - FIFO flushed in the same edge; a same-cycle pop and push are both cancelled.
  - PC<=redirectPC.
  - From ISSUE without grant: next state ISSUE; the new address is presented the next cycle and the old request is withdrawn.
  - From ISSUE with grant in the same cycle: the grant counts as outstanding, so next state DRAIN.
  - From WAIT with no rvalid: next state DRAIN.
  - From WAIT with rvalid in the same cycle: that response is discarded, next state ISSUE.
  - Redirect during DRAIN: update PC, stay in DRAIN.
- Consumer side:
  - Pop when o_IF_valid=1 and i_IF_stall=0.
  - Push and pop in the same cycle are allowed; occupancy is unchanged.
  - Push into an empty FIFO makes the word visible on o_IF_valid the next cycle, so the minimum latency from grant to decode is 2 cycles.
- Arithmetic:
  - PC+4 wraps modulo 2^32: 32'hFFFF_FFFC advances to 32'h0000_0000.
  - Each FIFO entry stores 32+32 bits; pointers are 1-bit, plus a 2-bit count.
- Stall with a full FIFO: req=0 and the PC is held indefinitely; nothing is lost.
- Reset during an outstanding access: the state is cleared, and a late rvalid arriving in ISSUE (outstanding=0) is ignored.

Decomposition:
- Shared package holds:
  - FSM state encoding: IF_ISSUE=2'd0, IF_WAIT=2'd1, IF_DRAIN=2'd2.
  - NOP_INST=32'h0.
  - PC_INC=32'd4.
- One natural sub-module: fetch_fifo, a 2-entry synchronous FIFO with push, pop, flush, count, and async active-high reset.

Test Plan:
- Reset, imem 1-cycle latency, no stall:
  - Required: requests to 0x0, 0x4, 0x8.
  - Decode sees (PC=0x4, inst=A), (0x8, B), … one per 2 cycles.
  - o_IF_valid=0 during reset.
- i_IF_stall=1 for 6 cycles after the first valid:
  - Required: the FIFO fills to 2, req deasserts, and the PC is held at 0x8.
  - On release, inst A then B are presented in order; the next request is 0x8.
- Redirect to 0x100 while WAIT, with rvalid 3 cycles later:
  - Required: that response is dropped and the FIFO is empty.
  - The next request has addr=0x100.
  - First valid output has PC=0x104.
- Redirect coinciding with grant of 0x10:
  - Required: DRAIN entered; the 0x10 response is never output.
  - The next request is the redirect target.
- Redirect to 0x0000_0203:
  - Required: a request is issued to 0x0000_0200.
- Redirect to 0xFFFF_FFFC:
  - Required: a request to 0xFFFF_FFFC, and its output has PC=0x0000_0000.
  - The next request has addr=0x0000_0000.
- Async rst asserted mid-WAIT, then a late rvalid:
  - Required: all outputs go to 0 immediately, and the late data is not pushed.
  - Fetching restarts at RESET_PC.
